ysyx_22041071_if_fetch: RTL and testbench



---
 rtl/ysyx_22041071_if_fetch.sv | 135 +++++++++++++
 tb/tb_ysyx_22041071_if_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests to
// imem, buffers returned words in a DEPTH-entry FIFO and hands them to decode.
// Latency: request accepted in cycle N (1-cycle memory) is valid2 in cycle N+2.
// Backpressure: issue is credit-limited so every in-flight word has a FIFO slot;
//   ready2=0 stalls issue, imem responses are never back-pressured.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   imem_req_valid/ready, addr    fetch request channel (addr = fetch_pc)
//   imem_rsp_valid, imem_rdata    in-order response channel
//   redirect_valid, redirect_pc   flush and restart fetch at target
//   valid2/ready2, PC2, Ins1      instruction handshake to decode
module ysyx_22041071_if_fetch #(
   parameter int                ADDR_W   = 64,
   parameter int                INS_W    = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INS_W-1:0]  imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              valid2,
   input  logic              ready2,
   output logic [ADDR_W-1:0] PC2,
   output logic [INS_W-1:0]  Ins1
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     fifo_count;
   logic [PW-1:0]     fifo_rd, fifo_wr;
   logic [PW-1:0]     tag_rd, tag_wr;
   logic [ADDR_W-1:0] tag_q    [DEPTH];
   logic [ADDR_W-1:0] fifo_pc  [DEPTH];
   logic [INS_W-1:0]  fifo_ins [DEPTH];

   logic [CW-1:0] live;
   logic [CW-1:0] outstanding_next;
   logic          credit_ok, slot_ok;
   logic          accept, drop_hit, push, pop, show;
   logic          unused_bits;

   // low target bits are forced to zero; only word-aligned fetch exists
   assign unused_bits = ^redirect_pc[1:0];

   // live words are those that will really land in the FIFO; together with
   // the FIFO occupancy they must never exceed DEPTH, which is what makes an
   // unstallable response stream safe
   assign live      = outstanding - drop;
   assign credit_ok = ({1'b0, live} + {1'b0, fifo_count}) < DEPTH_C;
   assign slot_ok   = {1'b0, outstanding} < DEPTH_C;

   assign imem_req_valid = !reset && !redirect_valid && credit_ok && slot_ok;
   assign imem_addr      = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign drop_hit = imem_rsp_valid && (drop != '0);
   assign push     = imem_rsp_valid && !drop_hit && !redirect_valid;

   assign show   = (fifo_count != '0) && !reset;
   assign valid2 = show && !redirect_valid;
   assign pop    = valid2 && ready2;
   assign PC2    = show ? fifo_pc[fifo_rd]  : '0;
   assign Ins1   = show ? fifo_ins[fifo_rd] : '0;

   assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         fifo_count  <= '0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else begin
         outstanding <= outstanding_next;

         // the tag queue tracks every in-flight request, stale or not, so it
         // advances on every response and is never flushed by a redirect
         if (accept) begin
            tag_q[tag_wr] <= fetch_pc;
            tag_wr        <= tag_wr + PW'(1);
         end
         if (imem_rsp_valid) begin
            tag_rd <= tag_rd + PW'(1);
         end

         if (redirect_valid) begin
            fetch_pc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            drop       <= outstanding_next;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (drop_hit) begin
               drop <= drop - CW'(1);
            end
            if (push) begin
               fifo_pc[fifo_wr]  <= tag_q[tag_rd];
               fifo_ins[fifo_wr] <= imem_rdata;
               fifo_wr           <= fifo_wr + PW'(1);
            end
            if (pop) begin
               fifo_rd <= fifo_rd + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ({1'b0, fifo_count} <= DEPTH_C);
         assert (drop <= outstanding);
         assert (!(imem_rsp_valid && (outstanding == '0)));
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_if_fetch.sv
module tb_ysyx_22041071_if_fetch;

   localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        valid2;
   logic        ready2;
   logic [63:0] PC2;
   logic [31:0] Ins1;

   ysyx_22041071_if_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .valid2         (valid2),
      .ready2         (ready2),
      .PC2            (PC2),
      .Ins1           (Ins1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;
   int rdy_pct = 100;
   int n_acc = 0;
   int n_del = 0;

   typedef struct { logic [63:0] addr; int due; } mreq_t;
   mreq_t       mq[$];
   logic [63:0] exp_req[$];
   logic [63:0] exp_out[$];

   always @(posedge clk) cyc <= cyc + 1;

   // memory contents: any fixed function of the word address
   function automatic logic [31:0] ins_of(input logic [63:0] a);
      return a[33:2] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // architectural view: after reset or redirect, fetch and delivery both
   // follow the sequential word stream starting at the aligned target
   task automatic restart(input logic [63:0] pc);
      exp_req.delete();
      exp_out.delete();
      for (int i = 0; i < 600; i++) begin
         exp_req.push_back(pc + 64'(4 * i));
         exp_out.push_back(pc + 64'(4 * i));
      end
   endtask

   // memory: record accepted requests, answer in order after lat cycles
   always @(negedge clk) begin
      if (reset) mq.delete();
      else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});
   end

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
      imem_req_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         imem_rsp_valid = 1'b0;
         imem_rdata     = '0;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = ins_of(mq[0].addr);
            void'(mq.pop_front());
         end
         imem_req_ready = ($urandom_range(99) < rdy_pct);
      end
   end

   // monitor / scoreboard
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
               n_acc++;
               if (exp_req.size() == 0) begin
                  total++; bad++;
                  $display("FAIL req_queue_empty actual=%h required=none", imem_addr);
               end else begin
                  e = exp_req.pop_front();
                  check("req_addr", imem_addr, e);
               end
            end
            if (valid2 && ready2) begin
               n_del++;
               if (exp_out.size() == 0) begin
                  total++; bad++;
                  $display("FAIL out_queue_empty actual=%h required=none", PC2);
               end else begin
                  e = exp_out.pop_front();
                  check("out_pc", PC2, e);
                  check("out_ins", 64'(Ins1), 64'(ins_of(e)));
               end
            end
            if (redirect_valid) begin
               check("redir_valid2_low", 64'(valid2), 64'd0);
               check("redir_req_low", 64'(imem_req_valid), 64'd0);
            end else if (!valid2) begin
               check("empty_pc2_zero", PC2, 64'd0);
               check("empty_ins1_zero", 64'(Ins1), 64'd0);
            end
         end
      end
   end

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1; redirect_valid = 1'b0;
      restart(RST);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int a0, d0;
      logic [63:0] t;
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ready2 = 1'b1;
      restart(RST);

      // reset state
      repeat (3) begin
         @(negedge clk);
         check("rst_req_valid", 64'(imem_req_valid), 64'd0);
         check("rst_valid2", 64'(valid2), 64'd0);
         check("rst_pc2", PC2, 64'd0);
         check("rst_ins1", 64'(Ins1), 64'd0);
      end

      // first fetches, 1-cycle memory
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("first_req_valid", 64'(imem_req_valid), 64'd1);
      check("first_req_addr", imem_addr, RST);
      check("first_valid2_low", 64'(valid2), 64'd0);
      @(negedge clk);
      check("second_req_addr", imem_addr, RST + 64'd4);
      check("second_valid2_low", 64'(valid2), 64'd0);
      @(negedge clk);
      check("lat2_valid2", 64'(valid2), 64'd1);
      check("lat2_pc2", PC2, RST);
      check("lat2_ins1", 64'(Ins1), 64'(ins_of(RST)));
      d0 = n_del;
      repeat (30) @(negedge clk);
      check("stream_progress", 64'(n_del - d0 >= 10), 64'd1);

      // decode stall: credits cap in-flight work at DEPTH
      ready2 = 1'b0;
      pulse_reset();
      a0 = n_acc;
      repeat (5) @(negedge clk);
      check("stall_pc2_mid", PC2, RST);
      repeat (5) @(negedge clk);
      check("stall_req_count", 64'(n_acc - a0), 64'd2);
      check("stall_valid2", 64'(valid2), 64'd1);
      check("stall_pc2_end", PC2, RST);
      @(posedge clk); #1; ready2 = 1'b1;
      d0 = n_del;
      repeat (30) @(negedge clk);
      check("stall_release_progress", 64'(n_del - d0 >= 10), 64'd1);

      // redirect with two requests in flight, 3-cycle memory
      lat = 3;
      pulse_reset();
      a0 = n_acc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = RST + 64'h100;
      restart(RST + 64'h100);
      @(negedge clk);
      check("two_in_flight", 64'(n_acc - a0), 64'd2);
      @(posedge clk); #1; redirect_valid = 1'b0;
      d0 = n_del;
      repeat (25) @(negedge clk);
      check("redir_resume", 64'(n_del > d0), 64'd1);

      // redirect coincident with a response and a would-be pop; unaligned target
      lat = 1;
      pulse_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = RST + 64'h102;
      restart(RST + 64'h100);
      @(negedge clk);
      @(posedge clk); #1; redirect_valid = 1'b0;
      @(negedge clk);
      check("coinc_valid2_low", 64'(valid2), 64'd0);
      check("coinc_pc2_zero", PC2, 64'd0);
      check("coinc_req_valid", 64'(imem_req_valid), 64'd1);
      check("coinc_aligned_addr", imem_addr, RST + 64'h100);
      repeat (20) @(negedge clk);

      // reset mid-stream with a full FIFO
      @(posedge clk); #1; ready2 = 1'b0;
      repeat (10) @(negedge clk);
      check("full_valid2", 64'(valid2), 64'd1);
      @(posedge clk); #1; reset = 1'b1; restart(RST);
      @(negedge clk);
      check("midrst_req_low", 64'(imem_req_valid), 64'd0);
      check("midrst_valid2_low", 64'(valid2), 64'd0);
      @(posedge clk); #1; reset = 1'b0; ready2 = 1'b1;
      @(negedge clk);
      check("postrst_valid2_low", 64'(valid2), 64'd0);
      check("postrst_req_valid", 64'(imem_req_valid), 64'd1);
      check("postrst_addr", imem_addr, RST);

      // random traffic: latency, memory ready, decode ready, redirects, resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (c % 200 == 0) begin
            lat     = $urandom_range(1, 4);
            rdy_pct = $urandom_range(50, 100);
         end
         ready2 = ($urandom_range(3) != 0);
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(199) == 0) begin
            reset = 1'b1; redirect_valid = 1'b0;
            restart(RST);
         end else if ($urandom_range(19) == 0) begin
            t = RST + 64'($urandom_range(0, 65535));
            redirect_valid = 1'b1; redirect_pc = t;
            restart(t & ~64'h3);
         end else begin
            redirect_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      reset = 1'b0; redirect_valid = 1'b0; ready2 = 1'b1; rdy_pct = 100;
      d0 = n_del;
      repeat (40) @(negedge clk);
      check("final_progress", 64'(n_del - d0 >= 10), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
